// File: rtl/dsp_post_adder_acc_pkg.sv
// Shared constants for the DSP48A1 post-adder/accumulator slice.
package dsp48a1_pkg;

    // Default datapath widths
    localparam int M_WIDTH_DEF = 36;
    localparam int P_WIDTH_DEF = 48;
    localparam int OPM_W       = 8;

    // Opmode bit positions
    localparam int OPM_SUB = 7;
    localparam int OPM_CIN = 5;

    // X operand select, opmode[1:0], positioned so they can be OR-ed into an opmode byte
    localparam logic [OPM_W-1:0] X_ZERO = 8'h00;
    localparam logic [OPM_W-1:0] X_M    = 8'h01;
    localparam logic [OPM_W-1:0] X_P    = 8'h02;
    localparam logic [OPM_W-1:0] X_DAB  = 8'h03;

    // Z operand select, opmode[3:2], positioned likewise
    localparam logic [OPM_W-1:0] Z_ZERO = 8'h00;
    localparam logic [OPM_W-1:0] Z_PCIN = 8'h04;
    localparam logic [OPM_W-1:0] Z_P    = 8'h08;
    localparam logic [OPM_W-1:0] Z_C    = 8'h0C;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand/control/result bundle of the post-adder stage.
interface dsp_post_adder_acc_if
    import dsp48a1_pkg::*;
#(
    parameter int M_WIDTH = M_WIDTH_DEF,
    parameter int P_WIDTH = P_WIDTH_DEF
);
    logic                 ce_opmode;
    logic                 ce_carryin;
    logic                 ce_p;
    logic [OPM_W-1:0]     opmode;
    logic [M_WIDTH-1:0]   m;
    logic [P_WIDTH-1:0]   dab;
    logic [P_WIDTH-1:0]   c;
    logic [P_WIDTH-1:0]   pcin;
    logic                 carryin;
    logic                 in_valid;
    logic [P_WIDTH-1:0]   p;
    logic [P_WIDTH-1:0]   pcout;
    logic                 carryout;
    logic                 carryoutf;
    logic                 out_valid;

    modport master (
        output ce_opmode, ce_carryin, ce_p, opmode, m, dab, c, pcin, carryin, in_valid,
        input  p, pcout, carryout, carryoutf, out_valid
    );

    modport slave (
        input  ce_opmode, ce_carryin, ce_p, opmode, m, dab, c, pcin, carryin, in_valid,
        output p, pcout, carryout, carryoutf, out_valid
    );
endinterface

// File: rtl/dsp_post_adder_acc_reg_n.sv
// Enabled register with asynchronous active-low clear; BYPASS=1 makes it a wire.
module dsp_reg_n #(
    parameter int WIDTH  = 1,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (BYPASS) begin : g_bypass
            assign q = d;
            // Clock, clear and enable have no function in the bypassed form
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, en};
        end else begin : g_reg
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;

            // Next state: load when enabled, otherwise hold
            always_comb begin
                data_d = data_q;
                if (en) begin
                    data_d = d;
                end
            end

            // State register; clear overrides the enable
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign q = data_q;
        end
    endgenerate
endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand select, add/sub with carry-in, P register.
module dsp_post_adder_acc
    import dsp48a1_pkg::*;
#(
    parameter int PREG       = 1,
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1,
    parameter     CARRYINSEL = "OPMODE5",
    parameter int M_WIDTH    = M_WIDTH_DEF,
    parameter int P_WIDTH    = P_WIDTH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    dsp_post_adder_acc_if.slave bus
);
    localparam bit USE_CIN_PORT = (CARRYINSEL == "CARRYIN");
    localparam int GRP_W        = P_WIDTH + 2;

    logic [OPM_W-1:0]   opmode_eff;
    logic               cin_sel;
    logic               cin_eff;
    logic [P_WIDTH-1:0] p_fb;
    logic [P_WIDTH-1:0] x_op;
    logic [P_WIDTH-1:0] z_op;
    logic [P_WIDTH:0]   sum;
    logic [GRP_W-1:0]   p_grp_d;
    logic [GRP_W-1:0]   p_grp_q;

    // Unsigned add or subtract at P_WIDTH+1 bits; the top bit is carry (add) or borrow (sub)
    function automatic logic [P_WIDTH:0] post_add(
        input logic [P_WIDTH-1:0] z,
        input logic [P_WIDTH-1:0] x,
        input logic               cin,
        input logic               sub
    );
        logic [P_WIDTH:0] z_ext;
        logic [P_WIDTH:0] x_ext;
        z_ext = {1'b0, z};
        x_ext = {1'b0, x} + {{P_WIDTH{1'b0}}, cin};
        return sub ? (z_ext - x_ext) : (z_ext + x_ext);
    endfunction

    // Opmode arrives one cycle ahead of its data, matching the upstream M register
    dsp_reg_n #(.WIDTH(OPM_W), .BYPASS(OPMODEREG == 0)) u_opmode_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.ce_opmode),
        .d     (bus.opmode),
        .q     (opmode_eff)
    );

    // Carry-in source is chosen before the register so it stays aligned with opmode
    assign cin_sel = USE_CIN_PORT ? bus.carryin : bus.opmode[OPM_CIN];

    dsp_reg_n #(.WIDTH(1), .BYPASS(CARRYINREG == 0)) u_cin_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.ce_carryin),
        .d     (cin_sel),
        .q     (cin_eff)
    );

    // Feedback only exists when P is registered; unregistered it would form a loop
    generate
        if (PREG != 0) begin : g_fb
            assign p_fb = p_grp_q[P_WIDTH-1:0];
        end else begin : g_no_fb
            assign p_fb = '0;
        end
    endgenerate

    // X and Z operand multiplexers
    always_comb begin
        x_op = '0;
        case (opmode_eff[1:0])
            X_M[1:0]:   x_op = {{(P_WIDTH-M_WIDTH){1'b0}}, bus.m};
            X_P[1:0]:   x_op = p_fb;
            X_DAB[1:0]: x_op = bus.dab;
            default:    x_op = '0;
        endcase
        z_op = '0;
        case (opmode_eff[3:2])
            Z_PCIN[3:2]: z_op = bus.pcin;
            Z_P[3:2]:    z_op = p_fb;
            Z_C[3:2]:    z_op = bus.c;
            default:     z_op = '0;
        endcase
    end

    // Post-adder and P-stage input group {out_valid, carryout, p}
    always_comb begin
        sum     = post_add(z_op, x_op, cin_eff, opmode_eff[OPM_SUB]);
        p_grp_d = {bus.in_valid, sum};
    end

    // P stage: result, carry-out and valid move together under ce_p
    dsp_reg_n #(.WIDTH(GRP_W), .BYPASS(PREG == 0)) u_p_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.ce_p),
        .d     (p_grp_d),
        .q     (p_grp_q)
    );

    assign bus.p         = p_grp_q[P_WIDTH-1:0];
    assign bus.pcout     = p_grp_q[P_WIDTH-1:0];
    assign bus.carryout  = p_grp_q[P_WIDTH];
    assign bus.carryoutf = p_grp_q[P_WIDTH];
    assign bus.out_valid = p_grp_q[P_WIDTH+1];

    // Opmode bits 4 and 6 are reserved; one of the two carry-in sources is always idle
    logic unused_inputs;
    assign unused_inputs = ^{opmode_eff[6], opmode_eff[4], bus.opmode[OPM_CIN], bus.carryin};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench for dsp_post_adder_acc: registered instance A, bypassed instance B.
module tb_dsp_post_adder_acc;
    import dsp48a1_pkg::*;

    localparam int MW = 36;
    localparam int PW = 48;
    localparam logic [PW-1:0] ONES = {PW{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsp_post_adder_acc_if #(.M_WIDTH(MW), .P_WIDTH(PW)) bus_a ();
    dsp_post_adder_acc_if #(.M_WIDTH(MW), .P_WIDTH(PW)) bus_b ();

    dsp_post_adder_acc #(
        .PREG(1), .OPMODEREG(1), .CARRYINREG(1), .CARRYINSEL("OPMODE5"),
        .M_WIDTH(MW), .P_WIDTH(PW)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    dsp_post_adder_acc #(
        .PREG(0), .OPMODEREG(0), .CARRYINREG(0), .CARRYINSEL("CARRYIN"),
        .M_WIDTH(MW), .P_WIDTH(PW)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [PW-1:0] p;
        logic          co;
        logic          ov;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on A, then queue what the P stage must hold after this edge
    task automatic cyc(input logic [7:0] op, input logic [MW-1:0] m, input logic [PW-1:0] dab,
                       input logic [PW-1:0] c, input logic iv, input logic cep, input logic ceo,
                       input logic cec, input string nm, input logic [PW-1:0] ep,
                       input logic eco, input logic eov);
        bus_a.opmode     = op;
        bus_a.m          = m;
        bus_a.dab        = dab;
        bus_a.c          = c;
        bus_a.in_valid   = iv;
        bus_a.ce_p       = cep;
        bus_a.ce_opmode  = ceo;
        bus_a.ce_carryin = cec;
        @(posedge clk);
        exp_q.push_back('{ep, eco, eov, nm});
        #1;
    endtask

    // Monitor: each queued entry is compared on the falling edge after its P-stage edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".p"},         bus_a.p,                  e.p);
                chk({e.name, ".pcout"},     bus_a.pcout,              e.p);
                chk({e.name, ".carryout"},  {47'd0, bus_a.carryout},  {47'd0, e.co});
                chk({e.name, ".carryoutf"}, {47'd0, bus_a.carryoutf}, {47'd0, e.co});
                chk({e.name, ".out_valid"}, {47'd0, bus_a.out_valid}, {47'd0, e.ov});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus_a.ce_opmode = 1'b1; bus_a.ce_carryin = 1'b1; bus_a.ce_p = 1'b1;
        bus_a.opmode = '0; bus_a.m = '0; bus_a.dab = '0; bus_a.c = '0;
        bus_a.pcin = '0; bus_a.carryin = 1'b0; bus_a.in_valid = 1'b0;
        bus_b.ce_opmode = 1'b1; bus_b.ce_carryin = 1'b1; bus_b.ce_p = 1'b1;
        bus_b.opmode = '0; bus_b.m = '0; bus_b.dab = '0; bus_b.c = '0;
        bus_b.pcin = '0; bus_b.carryin = 1'b0; bus_b.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.p",         bus_a.p,                 '0);
        chk("reset.carryout",  {47'd0, bus_a.carryout}, '0);
        chk("reset.out_valid", {47'd0, bus_a.out_valid},'0);
        rst_n = 1'b1;

        //  op     m  dab                c       iv  cep ceo cec  name          p              co   ov
        cyc(8'h09, 0, '0,                '0,     0,  1,  1,  1,   "warmup",     '0,            0,   0);
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "mac1",       48'd5,         0,   1);
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "mac2",       48'd10,        0,   1);
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "mac3",       48'd15,        0,   1);
        cyc(8'h0F, 5, '0,                '0,     1,  1,  1,  1,   "mac4",       48'd20,        0,   1);
        cyc(8'hAF, 0, ONES,              48'd1,  1,  1,  1,  1,   "wrap",       '0,            1,   1);
        cyc(8'hAF, 0, 48'd30,            48'd100,1,  1,  1,  1,   "sub_cin",    48'd69,        0,   1);
        cyc(8'h0F, 0, '0,                '0,     1,  1,  1,  1,   "borrow",     ONES,          1,   1);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h0F, 0, 48'd7 + 48'(i), 48'd3, 0,  0,  1,  1,   "ce_p_hold",  ONES,          1,   1);
        end
        cyc(8'hA9, 0, 48'd10,            48'd20, 1,  1,  0,  0,   "ceop_first", 48'd30,        0,   1);
        cyc(8'hA9, 0, 48'd1,             48'd2,  1,  1,  0,  0,   "ceop_hold",  48'd3,         0,   1);
        cyc(8'h2A, 0, 48'd5,             '0,     1,  1,  1,  1,   "load5",      48'd5,         0,   1);
        cyc(8'h2A, 0, '0,                '0,     1,  1,  1,  1,   "dbl1",       48'd11,        0,   1);
        cyc(8'h2A, 0, '0,                '0,     1,  1,  1,  1,   "dbl2",       48'd23,        0,   1);

        // Asynchronous reset mid-accumulation with ce_p still high
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async.p",         bus_a.p,                  '0);
        chk("rst_async.carryout",  {47'd0, bus_a.carryout},  '0);
        chk("rst_async.out_valid", {47'd0, bus_a.out_valid}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "post_rst0",  '0,            0,   1);
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "post_rst1",  48'd5,         0,   1);
        cyc(8'h09, 5, '0,                '0,     1,  1,  1,  1,   "post_rst2",  48'd10,        0,   1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 48'(exp_q.size()), '0);

        // Combinational instance: same-cycle results, P feedback reads zero
        bus_b.opmode = X_ZERO | Z_PCIN; bus_b.pcin = 48'h1234; bus_b.in_valid = 1'b1;
        #1;
        chk("bypass_pcin.p",         bus_b.p,                  48'h1234);
        chk("bypass_pcin.pcout",     bus_b.pcout,              48'h1234);
        chk("bypass_pcin.out_valid", {47'd0, bus_b.out_valid}, 48'd1);
        chk("bypass_pcin.carryout",  {47'd0, bus_b.carryout},  '0);
        bus_b.opmode = X_P | Z_P; bus_b.carryin = 1'b1;
        #1;
        chk("bypass_fb_cinport.p", bus_b.p, 48'd1);
        bus_b.opmode = X_P | Z_P | 8'h20; bus_b.carryin = 1'b0;
        #1;
        chk("bypass_fb_opm5_ignored.p", bus_b.p, '0);
        bus_b.opmode = X_P | Z_PCIN;
        #1;
        chk("bypass_xp_pcin.p", bus_b.p, 48'h1234);
        bus_b.opmode = X_ZERO | Z_C | 8'h80; bus_b.c = 48'd10; bus_b.carryin = 1'b1;
        bus_b.in_valid = 1'b0;
        #1;
        chk("bypass_sub.p",         bus_b.p,                  48'd9);
        chk("bypass_sub.carryoutf", {47'd0, bus_b.carryoutf}, '0);
        chk("bypass_sub.out_valid", {47'd0, bus_b.out_valid}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
